// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock; result W+1 edges after start.
// Optional BCD_LEADING_BLANK_EN adds a registered leading-zero blank mask (blank_out).
module bin_to_bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin_in,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd_out
`ifdef BCD_LEADING_BLANK_EN
  ,
  output logic [D-1:0]   blank_out
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]   shift_q;
  logic [4*D-1:0] acc_q;
  logic [4*D-1:0] acc_adj;
  logic [CW-1:0]  cnt_q;
  logic [4*D-1:0] bcd_q;
  logic           done_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == SHIFT);
    done    = done_q;
    bcd_out = bcd_q;
  end

  // Digits are corrected independently; no carry crosses a digit boundary.
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < D; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      else                         acc_adj[4*i +: 4] = acc_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            shift_q <= bin_in;
            acc_q   <= '0;
            cnt_q   <= CW'(W);
          end
        end
        SHIFT: begin
          {acc_q, shift_q} <= {acc_adj[4*D-2:0], shift_q, 1'b0};
          cnt_q            <= cnt_q - CW'(1);
        end
        DONE: begin
          bcd_q <= acc_q;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_LEADING_BLANK_EN
  logic [D-1:0] blank_nxt;
  logic [D-1:0] blank_q;
  logic         zero_above;

  // Walk from the top digit down; digit 0 always stays visible.
  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = D - 1; i >= 0; i--) begin
      zero_above   = zero_above & (acc_q[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_above;
    end
    blank_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset)              blank_q <= '0;
    else if (state == DONE)  blank_q <= blank_nxt;
  end

  assign blank_out = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (W=8, D=3); blank mask checked when BCD_LEADING_BLANK_EN is defined.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin_in = 8'd0;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
`ifdef BCD_LEADING_BLANK_EN
  logic [2:0]  blank_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W(8), .D(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef BCD_LEADING_BLANK_EN
    ,
    .blank_out (blank_out)
`endif
  );

  // Runs one conversion; n counts negedges after the accepting edge k (n=9 <=> done after edge k+9).
  task automatic run_conv(input logic [7:0] v, input int pulse_at, input logic [7:0] pulse_val,
                          output int first_done, output int done_cnt, output int busy_cnt,
                          output logic [11:0] res, output logic [2:0] blk);
    first_done = -1; done_cnt = 0; busy_cnt = 0; res = 'x; blk = 'x;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = n;
          res = bcd_out;
`ifdef BCD_LEADING_BLANK_EN
          blk = blank_out;
`endif
        end
      end
      start = 1'b0;
      if (n == pulse_at) begin
        start  = 1'b1;
        bin_in = pulse_val;
      end else if (pulse_at >= 0 && n == pulse_at + 1) begin
        bin_in = 8'd255;
      end
    end
  endtask

  task automatic test_reset();
    int dcnt = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd_out);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d cycles with busy/done high, required 0", dcnt);
    end
  endtask

  task automatic test_values();
    logic [7:0]  vals [4] = '{8'd255, 8'd0, 8'd100, 8'd99};
    logic [11:0] exps [4] = '{12'h255, 12'h000, 12'h100, 12'h099};
    int fd, dc, bc;
    logic [11:0] r;
    logic [2:0]  b;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], -1, 8'd0, fd, dc, bc, r, b);
      n_checks++;
      if (r !== exps[i]) begin
        n_fail++;
        $display("FAIL value_%0d: bcd=%h, required %h", vals[i], r, exps[i]);
      end
      n_checks++;
      if (fd !== 9 || dc !== 1) begin
        n_fail++;
        $display("FAIL latency_%0d: done at k+%0d count %0d, required k+9 count 1", vals[i], fd, dc);
      end
      n_checks++;
      if (bc !== 8) begin
        n_fail++;
        $display("FAIL busy_len_%0d: busy cycles %0d, required 8", vals[i], bc);
      end
    end
  endtask

  task automatic test_ignore_start();
    int fd, dc, bc;
    logic [11:0] r;
    logic [2:0]  b;
    run_conv(8'd42, 3, 8'd7, fd, dc, bc, r, b);
    n_checks++;
    if (r !== 12'h042 || fd !== 9) begin
      n_fail++;
      $display("FAIL ignore_start: bcd=%h at k+%0d, required 042 at k+9", r, fd);
    end
    n_checks++;
    if (dc !== 1) begin
      n_fail++;
      $display("FAIL ignore_start_pulses: done count %0d, required 1", dc);
    end
  endtask

  task automatic test_reset_mid();
    int fd, dc, bc;
    logic [11:0] r;
    logic [2:0]  b;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 3) reset = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd_out);
    end
    reset = 1'b1;
    run_conv(8'd13, -1, 8'd0, fd, dc, bc, r, b);
    n_checks++;
    if (r !== 12'h013 || fd !== 9 || dc !== 1) begin
      n_fail++;
      $display("FAIL after_reset: bcd=%h at k+%0d count %0d, required 013 at k+9 count 1", r, fd, dc);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, cnt = 0;
    logic [11:0] r1 = 'x, r2 = 'x;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd12;
    @(posedge clk);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (n == 0) bin_in = 8'd34;
      if (done === 1'b1) begin
        cnt++;
        if (d1 < 0) begin d1 = n; r1 = bcd_out; end
        else if (d2 < 0) begin d2 = n; r2 = bcd_out; end
      end
      if (n == 10) start = 1'b0;
    end
    n_checks++;
    if (d1 !== 9 || r1 !== 12'h012) begin
      n_fail++;
      $display("FAIL b2b_first: bcd=%h at k+%0d, required 012 at k+9", r1, d1);
    end
    n_checks++;
    if (d2 !== 19 || r2 !== 12'h034) begin
      n_fail++;
      $display("FAIL b2b_second: bcd=%h at k+%0d, required 034 at k+19", r2, d2);
    end
    n_checks++;
    if (cnt !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: done count %0d, required 2", cnt);
    end
  endtask

`ifdef BCD_LEADING_BLANK_EN
  task automatic test_blank();
    logic [7:0] vals [3] = '{8'd7, 8'd0, 8'd250};
    logic [2:0] exps [3] = '{3'b110, 3'b110, 3'b000};
    int fd, dc, bc;
    logic [11:0] r;
    logic [2:0]  b;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], -1, 8'd0, fd, dc, bc, r, b);
      n_checks++;
      if (b !== exps[i]) begin
        n_fail++;
        $display("FAIL blank_%0d: blank=%b, required %b", vals[i], b, exps[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_values();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef BCD_LEADING_BLANK_EN
    test_blank();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
